// File: rtl/mem_arb2.sv
// Two-client memory arbiter: round-robin grant into a single registered request slot,
// per-client outstanding limits, and combinational response routing by tag MSB.
module mem_arb2 #(
   parameter int unsigned ADDR_W  = 26,
   parameter int unsigned DATA_W  = 128,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   // client 0
   input  logic              c0_req_val_i,
   output logic              c0_req_rdy_o,
   input  logic [1:0]        c0_req_rw_i,
   input  logic [ADDR_W-1:0] c0_req_addr_i,
   input  logic [TAG_W-1:0]  c0_req_tag_i,
   input  logic [DATA_W-1:0] c0_req_data_i,
   output logic              c0_resp_val_o,
   output logic              c0_resp_nack_o,
   output logic [TAG_W-1:0]  c0_resp_tag_o,
   output logic [DATA_W-1:0] c0_resp_data_o,
   // client 1
   input  logic              c1_req_val_i,
   output logic              c1_req_rdy_o,
   input  logic [1:0]        c1_req_rw_i,
   input  logic [ADDR_W-1:0] c1_req_addr_i,
   input  logic [TAG_W-1:0]  c1_req_tag_i,
   input  logic [DATA_W-1:0] c1_req_data_i,
   output logic              c1_resp_val_o,
   output logic              c1_resp_nack_o,
   output logic [TAG_W-1:0]  c1_resp_tag_o,
   output logic [DATA_W-1:0] c1_resp_data_o,
   // memory side
   output logic              mem_req_val_o,
   input  logic              mem_req_rdy_i,
   output logic [1:0]        mem_req_rw_o,
   output logic [ADDR_W-1:0] mem_req_addr_o,
   output logic [DATA_W-1:0] mem_req_data_o,
   output logic [TAG_W:0]    mem_req_tag_o,
   input  logic              mem_resp_val_i,
   input  logic              mem_resp_nack_i,
   input  logic [TAG_W:0]    mem_resp_tag_i,
   input  logic [DATA_W-1:0] mem_resp_data_i
);

   localparam int unsigned CntW = $clog2(MAX_OUT + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_OUT);

   logic              val_q, val_d;
   logic [1:0]        rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [TAG_W:0]    tag_q, tag_d;
   logic              prio_q, prio_d;
   logic [CntW-1:0]   out0_q, out0_d, out1_q, out1_d;

   logic oreg_free, can0, can1, elig0, elig1, rdy0, rdy1, acc0, acc1;
   logic resp_any, resp_sel, dec0, dec1;

   always_comb begin
      oreg_free = !val_q || mem_req_rdy_i;
      can0      = rst_ni && oreg_free && (out0_q < MaxCnt);
      can1      = rst_ni && oreg_free && (out1_q < MaxCnt);
      elig0     = can0 && c0_req_val_i;
      elig1     = can1 && c1_req_val_i;
      // Each ready looks only at the other client's request, never its own valid.
      rdy0      = can0 && (!prio_q || !elig1);
      rdy1      = can1 && (prio_q || !elig0);
      acc0      = rdy0 && c0_req_val_i;
      acc1      = rdy1 && c1_req_val_i;
      resp_any  = mem_resp_val_i || mem_resp_nack_i;
      resp_sel  = mem_resp_tag_i[TAG_W];
      dec0      = resp_any && !resp_sel;
      dec1      = resp_any && resp_sel;
   end

   always_comb begin
      val_d  = val_q;
      rw_d   = rw_q;
      addr_d = addr_q;
      data_d = data_q;
      tag_d  = tag_q;
      prio_d = prio_q;
      if (acc0) begin
         val_d  = 1'b1;
         rw_d   = c0_req_rw_i;
         addr_d = c0_req_addr_i;
         data_d = c0_req_data_i;
         tag_d  = {1'b0, c0_req_tag_i};
         prio_d = 1'b1;
      end else if (acc1) begin
         val_d  = 1'b1;
         rw_d   = c1_req_rw_i;
         addr_d = c1_req_addr_i;
         data_d = c1_req_data_i;
         tag_d  = {1'b1, c1_req_tag_i};
         prio_d = 1'b0;
      end else if (mem_req_rdy_i) begin
         val_d = 1'b0;
      end
   end

   // Increment is only possible below MaxCnt; coinciding inc/dec cancel out.
   always_comb begin
      out0_d = out0_q;
      out1_d = out1_q;
      if (acc0 && !dec0) begin
         out0_d = out0_q + CntW'(1);
      end else if (dec0 && !acc0 && (out0_q != '0)) begin
         out0_d = out0_q - CntW'(1);
      end
      if (acc1 && !dec1) begin
         out1_d = out1_q + CntW'(1);
      end else if (dec1 && !acc1 && (out1_q != '0)) begin
         out1_d = out1_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         val_q  <= 1'b0;
         rw_q   <= '0;
         addr_q <= '0;
         data_q <= '0;
         tag_q  <= '0;
         prio_q <= 1'b0;
         out0_q <= '0;
         out1_q <= '0;
      end else begin
         val_q  <= val_d;
         rw_q   <= rw_d;
         addr_q <= addr_d;
         data_q <= data_d;
         tag_q  <= tag_d;
         prio_q <= prio_d;
         out0_q <= out0_d;
         out1_q <= out1_d;
      end
   end

   always_comb begin
      c0_req_rdy_o   = rdy0;
      c1_req_rdy_o   = rdy1;
      mem_req_val_o  = val_q;
      mem_req_rw_o   = rw_q;
      mem_req_addr_o = addr_q;
      mem_req_data_o = data_q;
      mem_req_tag_o  = tag_q;
      // Nack wins over val when memory raises both.
      c0_resp_val_o  = rst_ni && mem_resp_val_i && !mem_resp_nack_i && !resp_sel;
      c0_resp_nack_o = rst_ni && mem_resp_nack_i && !resp_sel;
      c1_resp_val_o  = rst_ni && mem_resp_val_i && !mem_resp_nack_i && resp_sel;
      c1_resp_nack_o = rst_ni && mem_resp_nack_i && resp_sel;
      c0_resp_tag_o  = mem_resp_tag_i[TAG_W-1:0];
      c1_resp_tag_o  = mem_resp_tag_i[TAG_W-1:0];
      c0_resp_data_o = mem_resp_data_i;
      c1_resp_data_o = mem_resp_data_i;
   end

endmodule

// File: tb/tb_mem_arb2.sv
// Randomized bench for mem_arb2 against a transaction-level reference model.
module tb_mem_arb2;

   localparam int MaxOut = 4;

   logic         clk, rst_ni;
   logic         c0_req_val, c0_req_rdy, c1_req_val, c1_req_rdy;
   logic [1:0]   c0_req_rw, c1_req_rw;
   logic [25:0]  c0_req_addr, c1_req_addr;
   logic [3:0]   c0_req_tag, c1_req_tag;
   logic [127:0] c0_req_data, c1_req_data;
   logic         c0_resp_val, c0_resp_nack, c1_resp_val, c1_resp_nack;
   logic [3:0]   c0_resp_tag, c1_resp_tag;
   logic [127:0] c0_resp_data, c1_resp_data;
   logic         mem_req_val, mem_req_rdy;
   logic [1:0]   mem_req_rw;
   logic [25:0]  mem_req_addr;
   logic [127:0] mem_req_data;
   logic [4:0]   mem_req_tag;
   logic         mem_resp_val, mem_resp_nack;
   logic [4:0]   mem_resp_tag;
   logic [127:0] mem_resp_data;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int           m_cnt[2];
   int           m_prio;
   bit           m_ov;
   logic [1:0]   m_rw;
   logic [25:0]  m_addr;
   logic [127:0] m_data;
   logic [4:0]   m_tag;

   mem_arb2 #(.ADDR_W(26), .DATA_W(128), .TAG_W(4), .MAX_OUT(MaxOut)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .c0_req_val_i(c0_req_val), .c0_req_rdy_o(c0_req_rdy), .c0_req_rw_i(c0_req_rw),
      .c0_req_addr_i(c0_req_addr), .c0_req_tag_i(c0_req_tag), .c0_req_data_i(c0_req_data),
      .c0_resp_val_o(c0_resp_val), .c0_resp_nack_o(c0_resp_nack),
      .c0_resp_tag_o(c0_resp_tag), .c0_resp_data_o(c0_resp_data),
      .c1_req_val_i(c1_req_val), .c1_req_rdy_o(c1_req_rdy), .c1_req_rw_i(c1_req_rw),
      .c1_req_addr_i(c1_req_addr), .c1_req_tag_i(c1_req_tag), .c1_req_data_i(c1_req_data),
      .c1_resp_val_o(c1_resp_val), .c1_resp_nack_o(c1_resp_nack),
      .c1_resp_tag_o(c1_resp_tag), .c1_resp_data_o(c1_resp_data),
      .mem_req_val_o(mem_req_val), .mem_req_rdy_i(mem_req_rdy), .mem_req_rw_o(mem_req_rw),
      .mem_req_addr_o(mem_req_addr), .mem_req_data_o(mem_req_data),
      .mem_req_tag_o(mem_req_tag), .mem_resp_val_i(mem_resp_val),
      .mem_resp_nack_i(mem_resp_nack), .mem_resp_tag_i(mem_resp_tag),
      .mem_resp_data_i(mem_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_prio   = 0;
      m_ov     = 1'b0;
      m_rw     = '0;
      m_addr   = '0;
      m_data   = '0;
      m_tag    = '0;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One clock cycle: drive, check combinational outputs, advance model, check registers.
   task automatic step(input bit force_both);
      bit free, e0, e1, sel, any_resp, acc0, acc1, d0, d1;
      int win;
      c0_req_val    = force_both ? 1'b1 : 1'($urandom_range(99) < 60);
      c1_req_val    = force_both ? 1'b1 : 1'($urandom_range(99) < 60);
      c0_req_rw     = 2'($urandom);
      c1_req_rw     = 2'($urandom);
      c0_req_addr   = 26'($urandom);
      c1_req_addr   = 26'($urandom);
      c0_req_tag    = 4'($urandom);
      c1_req_tag    = 4'($urandom);
      c0_req_data   = rand128();
      c1_req_data   = rand128();
      mem_req_rdy   = force_both ? 1'b1 : 1'($urandom_range(99) < 65);
      mem_resp_val  = 1'b0;
      mem_resp_nack = 1'b0;
      mem_resp_tag  = 5'($urandom);
      mem_resp_data = rand128();
      if (!force_both && (m_cnt[0] + m_cnt[1] > 0) && ($urandom_range(99) < 35)) begin
         int kind;
         if (m_cnt[0] == 0) sel = 1'b1;
         else if (m_cnt[1] == 0) sel = 1'b0;
         else sel = 1'($urandom);
         mem_resp_tag[4] = sel;
         kind = int'($urandom_range(2));
         mem_resp_val  = (kind != 1);
         mem_resp_nack = (kind != 0);
      end
      #1;
      free = !m_ov || mem_req_rdy;
      e0   = c0_req_val && free && (m_cnt[0] < MaxOut);
      e1   = c1_req_val && free && (m_cnt[1] < MaxOut);
      if (e0 && e1) win = m_prio;
      else if (e0) win = 0;
      else if (e1) win = 1;
      else win = -1;
      if (c0_req_val) check("c0_rdy", c0_req_rdy, (win == 0));
      if (c1_req_val) check("c1_rdy", c1_req_rdy, (win == 1));
      sel = mem_resp_tag[4];
      check("c0_resp_val", c0_resp_val, mem_resp_val && !mem_resp_nack && !sel);
      check("c1_resp_val", c1_resp_val, mem_resp_val && !mem_resp_nack && sel);
      check("c0_resp_nack", c0_resp_nack, mem_resp_nack && !sel);
      check("c1_resp_nack", c1_resp_nack, mem_resp_nack && sel);
      if (!sel) begin
         check("c0_resp_tag", c0_resp_tag, mem_resp_tag[3:0]);
         check("c0_resp_data", c0_resp_data, mem_resp_data);
      end else begin
         check("c1_resp_tag", c1_resp_tag, mem_resp_tag[3:0]);
         check("c1_resp_data", c1_resp_data, mem_resp_data);
      end
      acc0     = (win == 0);
      acc1     = (win == 1);
      any_resp = mem_resp_val || mem_resp_nack;
      d0       = any_resp && !sel;
      d1       = any_resp && sel;
      @(posedge clk);
      #1;
      if (acc0 || acc1) begin
         m_ov   = 1'b1;
         m_rw   = acc0 ? c0_req_rw : c1_req_rw;
         m_addr = acc0 ? c0_req_addr : c1_req_addr;
         m_data = acc0 ? c0_req_data : c1_req_data;
         m_tag  = acc0 ? {1'b0, c0_req_tag} : {1'b1, c1_req_tag};
         m_prio = acc0 ? 1 : 0;
      end else if (mem_req_rdy) begin
         m_ov = 1'b0;
      end
      if (acc0 && !d0) m_cnt[0]++;
      else if (d0 && !acc0 && m_cnt[0] > 0) m_cnt[0]--;
      if (acc1 && !d1) m_cnt[1]++;
      else if (d1 && !acc1 && m_cnt[1] > 0) m_cnt[1]--;
      check("mem_req_val", mem_req_val, m_ov);
      if (m_ov) begin
         check("mem_req_tag", mem_req_tag, m_tag);
         check("mem_req_addr", mem_req_addr, m_addr);
         check("mem_req_rw", mem_req_rw, m_rw);
         check("mem_req_data", mem_req_data, m_data);
      end
   endtask

   // Asynchronous reset in the middle of a stall, with requests and a response pending.
   task automatic reset_pulse();
      mem_req_rdy   = 1'b0;
      c0_req_val    = 1'b1;
      c1_req_val    = 1'b1;
      mem_resp_val  = 1'b1;
      mem_resp_nack = 1'b0;
      mem_resp_tag  = 5'h01;
      #1;
      rst_ni = 1'b0;
      #1;
      check("rst_mem_val_async", mem_req_val, 1'b0);
      check("rst_c0_rdy", c0_req_rdy, 1'b0);
      check("rst_c1_rdy", c1_req_rdy, 1'b0);
      check("rst_c0_resp_val", c0_resp_val, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      check("rst_mem_val", mem_req_val, 1'b0);
      check("rst_mem_addr", mem_req_addr, '0);
      check("rst_mem_tag", mem_req_tag, '0);
      check("rst_mem_data", mem_req_data, '0);
      rst_ni = 1'b1;
   endtask

   initial begin
      model_reset();
      rst_ni        = 1'b0;
      c0_req_val    = 1'b1;
      c1_req_val    = 1'b1;
      c0_req_rw     = '0;
      c1_req_rw     = '0;
      c0_req_addr   = 26'h100;
      c1_req_addr   = '0;
      c0_req_tag    = 4'h3;
      c1_req_tag    = '0;
      c0_req_data   = '0;
      c1_req_data   = '0;
      mem_req_rdy   = 1'b1;
      mem_resp_val  = 1'b1;
      mem_resp_nack = 1'b1;
      mem_resp_tag  = 5'h10;
      mem_resp_data = '0;
      #2;
      check("init_mem_val", mem_req_val, 1'b0);
      check("init_c0_rdy", c0_req_rdy, 1'b0);
      check("init_c1_rdy", c1_req_rdy, 1'b0);
      check("init_c1_resp_nack", c1_resp_nack, 1'b0);
      @(posedge clk);
      #1;
      check("init_mem_val_edge", mem_req_val, 1'b0);
      check("init_mem_rw", mem_req_rw, '0);
      rst_ni       = 1'b1;
      c0_req_val   = 1'b0;
      c1_req_val   = 1'b0;
      mem_resp_nack = 1'b0;
      mem_resp_tag = 5'h15;
      mem_resp_data = 128'hdead_beef;
      #1;
      check("route_c1_val", c1_resp_val, 1'b1);
      check("route_c1_tag", c1_resp_tag, 4'h5);
      check("route_c1_data", c1_resp_data, 128'hdead_beef);
      check("route_c0_val", c0_resp_val, 1'b0);
      check("route_c0_nack", c0_resp_nack, 1'b0);
      mem_resp_val = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (i == 700 || i == 1400) reset_pulse();
         step((i < 8) || (i == 700) || (i == 1400) || (i == 701) || (i == 1401));
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
